// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and helpers for the UART framing layer.
//   SYNC_DEFAULT : default frame start byte
//   tx_state_t   : transmit FSM states (one per frame byte plus idle)
//   rx_state_t   : receive FSM states (hunt for sync, then one per byte)
//   frame_chk()  : frame checksum, XOR of type and both payload bytes
package uart_frame_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SYNC,
        T_TYPE,
        T_DH,
        T_DL,
        T_CHK
    } tx_state_t;

    typedef enum logic [2:0] {
        R_HUNT,
        R_TYPE,
        R_DH,
        R_DL,
        R_CHK
    } rx_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] t,
                                             input logic [7:0] dh,
                                             input logic [7:0] dl);
        return t ^ dh ^ dl;
    endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: drains the UART receive FIFO, hunts for the sync byte,
// collects type/payload, validates the checksum and presents the message.
//   clk, reset      : clock, asynchronous active-low reset
//   rd_uart         : pop strobe to the RX FIFO (combinational, ~rx_empty)
//   r_data/rx_empty : RX FIFO head byte and empty flag
//   rx_valid        : one-cycle pulse, validated frame on rx_type/rx_data
//   rx_type/rx_data : last validated message, held between frames
//   rx_err          : one-cycle pulse on checksum mismatch or timeout
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC        = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 65_000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        rd_uart,
    input  logic [7:0]  r_data,
    input  logic        rx_empty,
    output logic        rx_valid,
    output logic [7:0]  rx_type,
    output logic [15:0] rx_data,
    output logic        rx_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    rx_state_t        state_q, state_d;
    logic [7:0]       type_sh_q, type_sh_d;
    logic [7:0]       dh_sh_q, dh_sh_d;
    logic [7:0]       dl_sh_q, dl_sh_d;
    logic [7:0]       xor_q, xor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       type_q, type_d;
    logic [15:0]      data_q, data_d;

    // Popping is gated by reset so nothing is consumed while held in reset.
    assign rd_uart = reset & ~rx_empty;

    always_comb begin
        state_d   = state_q;
        type_sh_d = type_sh_q;
        dh_sh_d   = dh_sh_q;
        dl_sh_d   = dl_sh_q;
        xor_d     = xor_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        type_d    = type_q;
        data_d    = data_q;

        if (rd_uart) begin
            // A consumed byte restarts the idle window and wins over a
            // timeout that would otherwise expire in the same cycle.
            cnt_d = '0;
            unique case (state_q)
                R_HUNT: begin
                    if (r_data == SYNC) state_d = R_TYPE;
                end
                R_TYPE: begin
                    type_sh_d = r_data;
                    xor_d     = r_data;
                    state_d   = R_DH;
                end
                R_DH: begin
                    dh_sh_d = r_data;
                    xor_d   = xor_q ^ r_data;
                    state_d = R_DL;
                end
                R_DL: begin
                    dl_sh_d = r_data;
                    xor_d   = xor_q ^ r_data;
                    state_d = R_CHK;
                end
                R_CHK: begin
                    if (r_data == xor_q) begin
                        valid_d = 1'b1;
                        type_d  = type_sh_q;
                        data_d  = {dh_sh_q, dl_sh_q};
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = R_HUNT;
                end
                default: state_d = R_HUNT;
            endcase
        end else if (state_q != R_HUNT) begin
            // Timeout fires on the TIMEOUT_CYC-th consecutive idle cycle
            // inside a frame; the error pulse is seen the following cycle.
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                state_d = R_HUNT;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= R_HUNT;
            type_sh_q <= '0;
            dh_sh_q   <= '0;
            dl_sh_q   <= '0;
            xor_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            type_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            type_sh_q <= type_sh_d;
            dh_sh_q   <= dh_sh_d;
            dl_sh_q   <= dl_sh_d;
            xor_q     <= xor_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            type_q    <= type_d;
            data_q    <= data_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_err   = err_q;
    assign rx_type  = type_q;
    assign rx_data  = data_q;

endmodule

// File: rtl/uart_frame_link.sv
// uart_frame_link: framing layer between game logic and the UART core.
// TX packs {SYNC, type, data_hi, data_lo, chk} into the UART TX FIFO;
// RX (uart_frame_rx) unpacks and validates frames from the UART RX FIFO.
//   clk, reset                 : clock, asynchronous active-low reset
//   tx_req/tx_type/tx_data     : send request and message (idle only)
//   tx_busy/tx_done            : frame in flight / final byte written
//   wr_uart/w_data/tx_full     : UART TX FIFO write side
//   rd_uart/r_data/rx_empty    : UART RX FIFO read side
//   rx_valid/rx_type/rx_data   : validated received message
//   rx_err                     : checksum or timeout error pulse
module uart_frame_link
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC        = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 65_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_req,
    input  logic [7:0]  tx_type,
    input  logic [15:0] tx_data,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    input  logic        tx_full,
    output logic        rd_uart,
    input  logic [7:0]  r_data,
    input  logic        rx_empty,
    output logic        rx_valid,
    output logic [7:0]  rx_type,
    output logic [15:0] rx_data,
    output logic        rx_err
);

    tx_state_t   state_q, state_d;
    logic [7:0]  type_q, type_d;
    logic [15:0] data_q, data_d;

    // Each byte state offers its byte whenever the FIFO has room and only
    // advances on an actual write, so a full FIFO stalls without loss.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        data_d  = data_q;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        tx_done = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                if (tx_req) begin
                    type_d  = tx_type;
                    data_d  = tx_data;
                    state_d = T_SYNC;
                end
            end
            T_SYNC: begin
                wr_uart = ~tx_full;
                w_data  = SYNC;
                if (wr_uart) state_d = T_TYPE;
            end
            T_TYPE: begin
                wr_uart = ~tx_full;
                w_data  = type_q;
                if (wr_uart) state_d = T_DH;
            end
            T_DH: begin
                wr_uart = ~tx_full;
                w_data  = data_q[15:8];
                if (wr_uart) state_d = T_DL;
            end
            T_DL: begin
                wr_uart = ~tx_full;
                w_data  = data_q[7:0];
                if (wr_uart) state_d = T_CHK;
            end
            T_CHK: begin
                wr_uart = ~tx_full;
                w_data  = frame_chk(type_q, data_q[15:8], data_q[7:0]);
                tx_done = wr_uart;
                if (wr_uart) state_d = T_IDLE;
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= T_IDLE;
            type_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            data_q  <= data_d;
        end
    end

    assign tx_busy = (state_q != T_IDLE);

    uart_frame_rx #(
        .SYNC        (SYNC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rd_uart  (rd_uart),
        .r_data   (r_data),
        .rx_empty (rx_empty),
        .rx_valid (rx_valid),
        .rx_type  (rx_type),
        .rx_data  (rx_data),
        .rx_err   (rx_err)
    );

endmodule

// File: tb/tb_uart_frame_link.sv
// Bench for uart_frame_link: a byte-queue model of both frame directions
// is checked against the DUT every cycle, plus literal expectations.
module tb_uart_frame_link;

    localparam int         T  = 20;
    localparam logic [7:0] SY = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_type = 8'h00;
    logic [15:0] tx_data = 16'h0000;
    logic        tx_busy, tx_done, wr_uart;
    logic [7:0]  w_data;
    logic        tx_full = 1'b0;
    logic        rd_uart;
    logic [7:0]  r_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rx_valid, rx_err;
    logic [7:0]  rx_type;
    logic [15:0] rx_data;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_frame_link #(.SYNC(SY), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(rst_n),
        .tx_req(tx_req), .tx_type(tx_type), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
        .rx_valid(rx_valid), .rx_type(rx_type), .rx_data(rx_data),
        .rx_err(rx_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RX FIFO emulation: head pops on a consumed cycle, flags refresh #1 later.
    logic [7:0] rxq[$];
    always @(posedge clk) begin
        if (rst_n && !rx_empty) void'(rxq.pop_front());
        #1;
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    end

    // Model: TX is a queue of bytes still owed; RX collects a frame as a byte list.
    logic [7:0]  txq[$];
    logic [7:0]  fr[$];
    int          idle;
    logic        e_valid, e_err;
    logic [7:0]  e_type;
    logic [15:0] e_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txq.delete(); fr.delete(); idle = 0;
            e_valid = 0; e_err = 0; e_type = 0; e_data = 0;
        end else begin
            e_valid = 0; e_err = 0;
            if (txq.size() != 0) begin
                if (!tx_full) void'(txq.pop_front());
            end else if (tx_req) begin
                txq.push_back(SY);
                txq.push_back(tx_type);
                txq.push_back(tx_data[15:8]);
                txq.push_back(tx_data[7:0]);
                txq.push_back(tx_type ^ tx_data[15:8] ^ tx_data[7:0]);
            end
            if (!rx_empty) begin
                idle = 0;
                if (fr.size() == 0) begin
                    if (r_data == SY) fr.push_back(r_data);
                end else begin
                    fr.push_back(r_data);
                    if (fr.size() == 5) begin
                        if (fr[4] == (fr[1] ^ fr[2] ^ fr[3])) begin
                            e_valid = 1; e_type = fr[1]; e_data = {fr[2], fr[3]};
                        end else begin
                            e_err = 1;
                        end
                        fr.delete();
                    end
                end
            end else if (fr.size() != 0) begin
                idle++;
                if (idle == T) begin
                    e_err = 1; fr.delete(); idle = 0;
                end
            end
        end
    end

    // Compare process and write/pulse logging.
    logic [7:0] txlog[$];
    logic       ew;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_tx_busy", tx_busy, 0);
            check("rst_tx_done", tx_done, 0);
            check("rst_wr_uart", wr_uart, 0);
            check("rst_w_data", w_data, 0);
            check("rst_rd_uart", rd_uart, 0);
            check("rst_rx_valid", rx_valid, 0);
            check("rst_rx_err", rx_err, 0);
            check("rst_rx_type", rx_type, 0);
            check("rst_rx_data", rx_data, 0);
        end else begin
            ew = (txq.size() != 0) && !tx_full;
            check("tx_busy", tx_busy, txq.size() != 0);
            check("wr_uart", wr_uart, ew);
            if (ew) begin
                check("w_data", w_data, txq[0]);
                check("tx_done", tx_done, txq.size() == 1);
            end else begin
                check("tx_done_idle", tx_done, 0);
            end
            check("rd_uart", rd_uart, !rx_empty);
            check("rx_valid", rx_valid, e_valid);
            check("rx_err", rx_err, e_err);
            check("rx_type", rx_type, e_type);
            check("rx_data", rx_data, e_data);
            if (wr_uart) txlog.push_back(w_data);
            if (rx_valid) n_valid++;
            if (rx_err) n_err++;
        end
    end

    task automatic send(input logic [7:0] t, input logic [15:0] d);
        tx_type = t; tx_data = d; tx_req = 1'b1;
        @(posedge clk); #1;
        tx_req = 1'b0;
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 200 && txq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("tx_idle_bound", txq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rx_drain();
        for (int i = 0; i < 200 && rxq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("rx_drain_bound", rxq.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic check_log(input string nm, input logic [39:0] exp);
        logic [39:0] e;
        e = exp;
        check({nm, "_len"}, txlog.size(), 5);
        for (int i = 0; i < 5 && i < txlog.size(); i++)
            check(nm, txlog[i], e[39-8*i -: 8]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain send; a request while busy must be ignored.
        txlog.delete();
        send(8'h03, 16'h1234);
        tx_type = 8'hFF; tx_data = 16'hFFFF; tx_req = 1'b1;
        @(posedge clk); #1;
        tx_req = 1'b0;
        wait_tx_idle();
        check_log("send_bytes", 40'hA5_03_12_34_25);

        // Stall after the second byte for 10 cycles.
        txlog.delete();
        send(8'h5A, 16'hC381);
        for (int i = 0; i < 20 && txlog.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        check("stall_pos", txlog.size(), 2);
        tx_full = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("stall_no_write", txlog.size(), 2);
        tx_full = 1'b0;
        wait_tx_idle();
        check_log("stall_bytes", 40'hA5_5A_C3_81_18);

        // Receive with leading junk; checksum 07^BE^EF = 56.
        n_valid = 0; n_err = 0;
        push(8'h00); push(SY); push(8'h07); push(8'hBE); push(8'hEF); push(8'h56);
        wait_rx_drain();
        check("rx1_nvalid", n_valid, 1);
        check("rx1_nerr", n_err, 0);
        check("rx1_type", rx_type, 8'h07);
        check("rx1_data", rx_data, 16'hBEEF);

        // Bad checksum, then a good frame (11^22^33 = 00).
        n_valid = 0; n_err = 0;
        push(SY); push(8'h07); push(8'hBE); push(8'hEF); push(8'h77);
        wait_rx_drain();
        check("bad_nerr", n_err, 1);
        check("bad_nvalid", n_valid, 0);
        check("bad_hold_type", rx_type, 8'h07);
        check("bad_hold_data", rx_data, 16'hBEEF);
        push(SY); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
        wait_rx_drain();
        check("good2_nvalid", n_valid, 1);
        check("good2_data", rx_data, 16'h2233);

        // Timeout inside a frame, then recovery.
        n_valid = 0; n_err = 0;
        push(SY); push(8'h01);
        wait_rx_drain();
        repeat (T + 5) begin @(posedge clk); #1; end
        check("to_nerr", n_err, 1);
        check("to_nvalid", n_valid, 0);
        push(SY); push(8'h01); push(8'h00); push(8'h02); push(8'h03);
        wait_rx_drain();
        check("to_rec_nvalid", n_valid, 1);
        check("to_rec_type", rx_type, 8'h01);
        check("to_rec_data", rx_data, 16'h0002);

        // Reset in the middle of both frames.
        txlog.delete();
        push(SY); push(8'h07);
        send(8'h44, 16'h5566);
        for (int i = 0; i < 20 && txlog.size() < 3; i++) begin
            @(posedge clk); #1;
        end
        check("rst_pos", txlog.size(), 3);
        rst_n = 1'b0;
        #1;
        check("rst_async_data", rx_data, 16'h0000);
        check("rst_async_busy", tx_busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        txlog.delete();
        n_valid = 0; n_err = 0;
        push(SY); push(8'h07); push(8'hBE); push(8'hEF); push(8'h56);
        send(8'h03, 16'h1234);
        wait_tx_idle();
        wait_rx_drain();
        check_log("post_rst_bytes", 40'hA5_03_12_34_25);
        check("post_rst_nvalid", n_valid, 1);
        check("post_rst_nerr", n_err, 0);
        check("post_rst_data", rx_data, 16'hBEEF);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
